// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the AXI-Stream fed UART transmitter:
//   parity_t     - parity mode selector
//   tx_state_t   - transmitter state encoding
//   calc_div     - clock cycles per serial bit
//   parity_bit   - parity bit of a (zero-extended) data word
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per serial bit (integer division, remainder dropped).
    function automatic int calc_div(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Parity bit for a data word. Unused upper bits must be zero so they do
    // not disturb the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] data, input parity_t mode);
        logic x;
        x = ^data;
        case (mode)
            PAR_EVEN: return x;
            PAR_ODD:  return ~x;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised synchronous FIFO with show-ahead read data and an occupancy
// count.
//   clk, rst_n   - clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  - write request and data (ignored when full unless a pop
//                  happens in the same cycle)
//   pop, rdata   - read request and the word at the head of the FIFO
//   full, empty  - status flags
//   level        - number of words held (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == LW'(0));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push at full is legal then.
    assign rd_en_s = pop & ~empty;
    assign wr_en_s = push & (~full | rd_en_s);

    // Next pointer and occupancy values; push+pop together leaves level alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_en_s && !rd_en_s) begin
            level_d = level_q + LW'(1);
        end else if (rd_en_s && !wr_en_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/axis_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// axis_uart_tx_fifo
// UART transmitter fed from an AXI-Stream slave through a transmit FIFO, with
// hardware flow control on cts_n.
//   aclk, aresetn   - clock, asynchronous active-low reset (aborts any frame)
//   tdata, tvalid,
//   tready          - AXIS slave; only tdata[DATA_BITS-1:0] is used
//   cts_n           - asynchronous clear-to-send, active-low; gates new frames
//   tx              - registered serial output, idle high
//   busy            - high while a frame is on tx
//   fifo_level      - words waiting in the transmit FIFO
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS
// stop bits(1); every bit lasts DIV = CLK_FREQ_HZ/BIT_RATE cycles.
// -----------------------------------------------------------------------------
module axis_uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int      CLK_FREQ_HZ = 100_000_000,
    parameter  int      BIT_RATE    = 115200,
    parameter  int      DATA_BITS   = 8,
    parameter  parity_t PARITY      = PAR_NONE,
    parameter  int      STOP_BITS   = 1,
    parameter  int      FIFO_DEPTH  = 16,
    localparam int      TDATA_W     = 8 * ((DATA_BITS + 7) / 8),
    localparam int      LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [TDATA_W-1:0] tdata,
    input  logic               tvalid,
    output logic               tready,
    input  logic               cts_n,
    output logic               tx,
    output logic               busy,
    output logic [LVL_W-1:0]   fifo_level
);

    localparam int               DIV       = calc_div(CLK_FREQ_HZ, BIT_RATE);
    localparam int               CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    // cts synchroniser
    logic cts_meta_q, cts_sync_q;

    // tready is held low until the first edge after reset release
    logic rdy_q, rdy_d;

    // transmitter FSM
    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    // FIFO interface
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_rdata_s;

    logic                 start_ok_s;
    logic                 bit_end_s;
    logic                 load_par_s;

    assign tready     = rdy_q & ~fifo_full_s;
    assign push_s     = tvalid & tready;
    assign tx         = tx_q;
    assign busy       = busy_q;

    assign start_ok_s = ~fifo_empty_s & ~cts_sync_q;
    assign bit_end_s  = (cnt_q == CNT_LAST);
    assign load_par_s = parity_bit(9'(fifo_rdata_s), PARITY);
    assign rdy_d      = 1'b1;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (push_s),
        .wdata (tdata[DATA_BITS-1:0]),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Two-flop synchroniser for cts_n; resets to "not clear".
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    // Post-reset ready enable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rdy_d;
        end
    end

    // FSM next state, bit-period counter, shift register and line outputs.
    // tx/busy are decoded from the current state and registered, so the line
    // trails the state by one cycle; every state still lasts exactly DIV
    // cycles so frames stay contiguous on the line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pop_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = 4'd0;
                if (start_ok_s) begin
                    state_d = ST_START;
                    pop_s   = 1'b1;
                    shreg_d = fifo_rdata_s;
                    par_d   = load_par_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = 4'd0;
                        // Chain straight into the next frame when possible.
                        if (start_ok_s) begin
                            state_d = ST_START;
                            pop_s   = 1'b1;
                            shreg_d = fifo_rdata_s;
                            par_d   = load_par_s;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = 4'd0;
            end
        endcase

        case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_q[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_q != ST_IDLE);
    end

    // FSM and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
// Bench for axis_uart_tx_fifo at 1 MHz / 100 kbit/s (10 cycles per bit).
// Five instances cover 8N1 (depth 4), 8E1, 8O1, 7E2 and 9N1.
module tb_axis_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int RATE   = 100_000;
    localparam int DIV    = 10;
    localparam int NI     = 5;
    localparam int DB [NI] = '{8, 8, 8, 7, 9};
    localparam int PM [NI] = '{0, 2, 1, 2, 0};   // 0 none, 1 odd, 2 even
    localparam int SB [NI] = '{1, 1, 1, 2, 1};

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] td8 [4];
    logic [15:0] td16;
    logic       tvalid_a [NI];
    logic       cts_a    [NI];
    logic       tready_a [NI];
    logic       tx_a     [NI];
    logic       busy_a   [NI];
    logic [2:0] lvl0;
    logic [4:0] lvl_o [1:4];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axis_uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BIT_RATE(RATE), .DATA_BITS(8),
        .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn), .tdata(td8[0]), .tvalid(tvalid_a[0]),
        .tready(tready_a[0]), .cts_n(cts_a[0]), .tx(tx_a[0]), .busy(busy_a[0]),
        .fifo_level(lvl0));

    axis_uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BIT_RATE(RATE), .DATA_BITS(8),
        .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .tdata(td8[1]), .tvalid(tvalid_a[1]),
        .tready(tready_a[1]), .cts_n(cts_a[1]), .tx(tx_a[1]), .busy(busy_a[1]),
        .fifo_level(lvl_o[1]));

    axis_uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BIT_RATE(RATE), .DATA_BITS(8),
        .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut2 (
        .aclk(aclk), .aresetn(aresetn), .tdata(td8[2]), .tvalid(tvalid_a[2]),
        .tready(tready_a[2]), .cts_n(cts_a[2]), .tx(tx_a[2]), .busy(busy_a[2]),
        .fifo_level(lvl_o[2]));

    axis_uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BIT_RATE(RATE), .DATA_BITS(7),
        .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut3 (
        .aclk(aclk), .aresetn(aresetn), .tdata(td8[3]), .tvalid(tvalid_a[3]),
        .tready(tready_a[3]), .cts_n(cts_a[3]), .tx(tx_a[3]), .busy(busy_a[3]),
        .fifo_level(lvl_o[3]));

    axis_uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BIT_RATE(RATE), .DATA_BITS(9),
        .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn), .tdata(td16), .tvalid(tvalid_a[4]),
        .tready(tready_a[4]), .cts_n(cts_a[4]), .tx(tx_a[4]), .busy(busy_a[4]),
        .fifo_level(lvl_o[4]));

    task automatic set_word(input int idx, input int w);
        if (idx == 4) td16 = w[15:0];
        else          td8[idx] = w[7:0];
    endtask

    // Present one word and wait for the handshake; returns on the negedge
    // that follows the accepting edge.
    task automatic push_word(input int idx, input int w, input string tag);
        logic rdy;
        bit   ok = 1'b0;
        set_word(idx, w);
        tvalid_a[idx] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            rdy = tready_a[idx];
            @(negedge aclk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        tvalid_a[idx] = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s push: accepted %0d required 1", tag, ok);
        end
    endtask

    // Wait (at most budget cycles) for a start bit, then compare every cycle
    // of the frame against the serial framing rules for instance idx.
    task automatic rx_frame(input int idx, input int w, input int budget,
                            input string tag, output int t0);
        logic [12:0] e;
        int   nb, d, ones, n;
        logic got;
        bit   bad, busy_bad;
        d  = w & ((1 << DB[idx]) - 1);
        e  = '0;
        e[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < DB[idx]; i++) begin
            e[nb] = ((d >> i) & 1) != 0;
            nb++;
        end
        if (PM[idx] != 0) begin
            ones  = $countones(d);
            e[nb] = (PM[idx] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            nb++;
        end
        for (int i = 0; i < SB[idx]; i++) begin
            e[nb] = 1'b1;
            nb++;
        end
        n = 0;
        while (tx_a[idx] !== 1'b0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (tx_a[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s start: tx %b required 0 within %0d cycles", tag, tx_a[idx], budget);
            t0 = -1;
            return;
        end
        t0 = cyc;
        busy_bad = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bad = 1'b0;
            got = e[b];
            for (int s = 0; s < DIV; s++) begin
                if (tx_a[idx] !== e[b]) begin
                    bad = 1'b1;
                    got = tx_a[idx];
                end
                if (busy_a[idx] !== 1'b1) busy_bad = 1'b1;
                @(negedge aclk);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit%0d: tx %b required %b (word %0h)", tag, b, got, e[b], d);
            end
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s busy: dropped during frame, required 1", tag);
        end
    endtask

    task automatic check_idle(input int idx, input string tag);
        checks++;
        if (tx_a[idx] !== 1'b1 || busy_a[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: tx %b busy %b required tx 1 busy 0", tag, tx_a[idx], busy_a[idx]);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        td16 = '0;
        for (int i = 0; i < NI; i++) begin
            tvalid_a[i] = 1'b0;
            cts_a[i]    = 1'b0;
            if (i < 4) td8[i] = '0;
        end
        repeat (3) @(negedge aclk);
        checks++;
        if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || tready_a[0] !== 1'b0 || lvl0 !== 3'd0) begin
            errors++;
            $display("FAIL reset0: tx %b busy %b tready %b level %0d required 1 0 0 0",
                     tx_a[0], busy_a[0], tready_a[0], lvl0);
        end
        for (int i = 1; i < NI; i++) begin
            checks++;
            if (tx_a[i] !== 1'b1 || tready_a[i] !== 1'b0 || lvl_o[i] !== 5'd0) begin
                errors++;
                $display("FAIL reset%0d: tx %b tready %b level %0d required 1 0 0",
                         i, tx_a[i], tready_a[i], lvl_o[i]);
            end
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (tready_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_no_edge: tready %b required 0", tready_a[0]);
        end
        @(negedge aclk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (tready_a[i] !== 1'b1) begin
                errors++;
                $display("FAIL release_tready%0d: tready %b required 1", i, tready_a[i]);
            end
        end
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_latency_8n1();
        logic c1, c2;
        int   t0;
        push_word(0, 32'h55, "lat");
        c1 = tx_a[0];
        @(negedge aclk);
        c2 = tx_a[0];
        @(negedge aclk);
        checks++;
        if (c1 !== 1'b1 || c2 !== 1'b1 || tx_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency: tx after edges 0,1,2 = %b%b%b required 110", c1, c2, tx_a[0]);
        end
        rx_frame(0, 32'h55, 0, "8n1_55", t0);
        check_idle(0, "8n1_55");
    endtask

    task automatic test_parity_modes();
        int w, t0;
        for (int k = 0; k < 4; k++) begin
            for (int idx = 1; idx <= 3; idx++) begin
                if (k == 0) w = (idx == 3) ? 32'h7F : 32'h07;
                else        w = int'($urandom_range(0, 255));
                push_word(idx, w, "par");
                rx_frame(idx, w, 5, $sformatf("par%0d_%0d", idx, k), t0);
                check_idle(idx, "par");
            end
        end
    endtask

    task automatic test_nine_bit();
        int w, t0;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 32'h1A5 : int'($urandom_range(0, 511));
            push_word(4, w, "9n1");
            rx_frame(4, w, 5, $sformatf("9n1_%0d", k), t0);
            check_idle(4, "9n1");
        end
    endtask

    task automatic test_fifo_full();
        int   w [5];
        int   t [4];
        logic rdy;
        bit   ok, rdy_seen, tx_moved;
        for (int k = 0; k < 5; k++) w[k] = int'($urandom_range(0, 255));
        cts_a[0] = 1'b1;
        repeat (4) @(negedge aclk);
        tx_moved = 1'b0;
        tvalid_a[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_word(0, w[k]);
            ok = 1'b0;
            for (int n = 0; n < 20; n++) begin
                rdy = tready_a[0];
                @(negedge aclk);
                if (tx_a[0] !== 1'b1) tx_moved = 1'b1;
                if (rdy) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL full_push%0d: accepted 0 required 1", k);
            end
        end
        set_word(0, w[4]);
        rdy_seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (tready_a[0] !== 1'b0) rdy_seen = 1'b1;
            if (tx_a[0] !== 1'b1) tx_moved = 1'b1;
            @(negedge aclk);
        end
        tvalid_a[0] = 1'b0;
        checks++;
        if (rdy_seen) begin
            errors++;
            $display("FAIL full_tready: tready 1 seen required 0 while full");
        end
        checks++;
        if (lvl0 !== 3'd4) begin
            errors++;
            $display("FAIL full_level: level %0d required 4", lvl0);
        end
        checks++;
        if (tx_moved) begin
            errors++;
            $display("FAIL full_cts_hold: tx left 1 while cts_n high");
        end
        cts_a[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rx_frame(0, w[k], (k == 0) ? 20 : 0, $sformatf("b2b%0d", k), t[k]);
            if (k > 0) begin
                checks++;
                if (t[k] - t[k-1] != 100) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: spacing %0d required 100", k, t[k] - t[k-1]);
                end
            end
        end
        check_idle(0, "b2b_end");
    endtask

    task automatic test_cts_pause();
        int  w1, w2, t0, t1;
        bit  moved;
        w1 = int'($urandom_range(0, 255));
        w2 = int'($urandom_range(0, 255));
        cts_a[0] = 1'b0;
        push_word(0, w1, "cts1");
        push_word(0, w2, "cts2");
        fork
            rx_frame(0, w1, 20, "cts_f1", t0);
            begin
                repeat (35) @(negedge aclk);
                cts_a[0] = 1'b1;
            end
        join
        moved = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) moved = 1'b1;
            @(negedge aclk);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL cts_block: frame started with cts_n high");
        end
        checks++;
        if (lvl0 !== 3'd1) begin
            errors++;
            $display("FAIL cts_level: level %0d required 1", lvl0);
        end
        cts_a[0] = 1'b0;
        rx_frame(0, w2, 10, "cts_f2", t1);
        check_idle(0, "cts_end");
    endtask

    task automatic test_reset_midframe();
        int w1, w2, w3, t0, n;
        w1 = int'($urandom_range(0, 255)) & 32'hFB;
        w2 = int'($urandom_range(0, 255));
        w3 = int'($urandom_range(0, 255));
        push_word(0, w1, "rst1");
        push_word(0, w2, "rst2");
        n = 0;
        while (tx_a[0] !== 1'b0 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        repeat (35) @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || lvl0 !== 3'd0 || tready_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx %b busy %b level %0d tready %b required 1 0 0 0",
                     tx_a[0], busy_a[0], lvl0, tready_a[0]);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        push_word(0, w3, "rst3");
        rx_frame(0, w3, 5, "post_rst", t0);
        check_idle(0, "post_rst");
        checks++;
        if (lvl0 !== 3'd0) begin
            errors++;
            $display("FAIL post_rst_level: level %0d required 0", lvl0);
        end
    endtask

    initial begin
        test_reset();
        test_latency_8n1();
        test_parity_modes();
        test_nine_bit();
        test_fifo_full();
        test_cts_pause();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
